// File: rtl/mult_sequencer_pkg.sv
// Shared constants for the execute-stage multiply sequencer: ALU control
// codes for the two multiply flavours and the 2-bit FSM state encoding.
package mult_sequencer_pkg;

   localparam logic [5:0] OP_MULT  = 6'h0e;
   localparam logic [5:0] OP_MULTU = 6'h16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   function automatic logic is_mult_op(input logic [5:0] ctr);
      return (ctr == OP_MULT) || (ctr == OP_MULTU);
   endfunction

endpackage

// File: rtl/mult_timeout_cnt.sv
// Watchdog counter for a pending multiply: cleared at launch, counts while
// waiting, and flags the last permitted wait cycle.
module mult_timeout_cnt #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Saturates at the terminal value so a held enable never wraps around.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !terminal) begin
         count <= count + CNT_W'(1);
      end
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/mult_sequencer.sv
// Launches the multi-cycle multipliers for mult/multu in EX, stalls the
// pipeline until completion (or timeout) and presents the product for one cycle.
module mult_sequencer
   import mult_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [5:0]  ALU_ctr,
   input  logic [31:0] busA,
   input  logic [31:0] busB,
   input  logic        mult_done,
   input  logic [31:0] mult_res,
   input  logic [31:0] multu_res,
   output logic        doMult,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic        stall,
   output logic        res_valid,
   output logic [31:0] result,
   output logic        timeout_err
);

   logic [1:0] state;
   logic [1:0] state_next;
   logic       signed_op;
   logic       is_mult;
   logic       cnt_terminal;

   assign is_mult = ex_valid && is_mult_op(ALU_ctr);

   mult_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == ST_LAUNCH),
      .enable   (state == ST_WAIT),
      .terminal (cnt_terminal)
   );

   // EX inputs only matter in IDLE; DONE always returns to IDLE so the
   // retiring multiply can never relaunch itself.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (is_mult) state_next = ST_LAUNCH;
         ST_LAUNCH: state_next = ST_WAIT;
         ST_WAIT:   if (mult_done || cnt_terminal) state_next = ST_DONE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Completion takes priority over timeout when both land in one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mult_a      <= '0;
         mult_b      <= '0;
         signed_op   <= 1'b0;
         result      <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_mult) begin
                  mult_a    <= busA;
                  mult_b    <= busB;
                  signed_op <= (ALU_ctr == OP_MULT);
               end
            end
            ST_WAIT: begin
               if (mult_done) begin
                  result <= signed_op ? mult_res : multu_res;
               end else if (cnt_terminal) begin
                  result      <= '0;
                  timeout_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign doMult    = (state == ST_LAUNCH);
   assign res_valid = (state == ST_DONE);
   assign stall     = (state == ST_LAUNCH) || (state == ST_WAIT) ||
                      ((state == ST_IDLE) && is_mult);

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized self-checking bench for mult_sequencer; expected products,
// timing and the sticky error flag come from a transaction-level model.
module tb_mult_sequencer;

   localparam int TIMEOUT = 40;
   localparam logic [5:0] C_MULT  = 6'h0e;
   localparam logic [5:0] C_MULTU = 6'h16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [5:0]  ALU_ctr;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        mult_done;
   logic [31:0] mult_res;
   logic [31:0] multu_res;
   logic        doMult;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic        stall;
   logic        res_valid;
   logic [31:0] result;
   logic        timeout_err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_result = '0;
   logic        model_err = 1'b0;

   mult_sequencer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (6)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ex_valid    (ex_valid),
      .ALU_ctr     (ALU_ctr),
      .busA        (busA),
      .busB        (busB),
      .mult_done   (mult_done),
      .mult_res    (mult_res),
      .multu_res   (multu_res),
      .doMult      (doMult),
      .mult_a      (mult_a),
      .mult_b      (mult_b),
      .stall       (stall),
      .res_valid   (res_valid),
      .result      (result),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One multiply transaction. done_delay counts WAIT cycles before mult_done
   // (>= TIMEOUT means never); reset_at >= 0 pulls reset on that WAIT cycle.
   task automatic applyStimulus(input bit is_signed, input logic [31:0] a, input logic [31:0] b,
                                input int done_delay, input bit stale, input bit idle_after,
                                input int reset_at);
      logic [31:0] prod;
      logic [31:0] exp_res;
      bit          timed_out;
      if (is_signed)
         prod = 32'(longint'($signed(a)) * longint'($signed(b)));
      else
         prod = 32'(longint'({32'b0, a}) * longint'({32'b0, b}));
      timed_out = (done_delay >= TIMEOUT);
      exp_res   = timed_out ? 32'h0 : prod;

      // detect cycle (IDLE)
      ex_valid  = 1'b1;
      ALU_ctr   = is_signed ? C_MULT : C_MULTU;
      busA      = a;
      busB      = b;
      mult_done = stale;
      #1;
      checkOutput("detect_stall", 32'(stall), 32'd1);
      checkOutput("detect_doMult", 32'(doMult), 32'd0);
      checkOutput("idle_res_valid", 32'(res_valid), 32'd0);
      checkOutput("result_hold", result, model_result);
      tick();

      // launch cycle: EX inputs are garbage and must be ignored
      ex_valid  = 1'($urandom);
      ALU_ctr   = 6'($urandom);
      busA      = $urandom;
      busB      = $urandom;
      mult_done = stale;
      #1;
      checkOutput("launch_doMult", 32'(doMult), 32'd1);
      checkOutput("launch_stall", 32'(stall), 32'd1);
      checkOutput("mult_a", mult_a, a);
      checkOutput("mult_b", mult_b, b);
      tick();

      for (int i = 0; i < TIMEOUT; i++) begin
         mult_done = (i == done_delay);
         mult_res  = is_signed ? prod : $urandom;
         multu_res = is_signed ? $urandom : prod;
         ex_valid  = 1'($urandom);
         ALU_ctr   = is_signed ? C_MULTU : C_MULT;
         #1;
         checkOutput("wait_doMult", 32'(doMult), 32'd0);
         checkOutput("wait_stall", 32'(stall), 32'd1);
         checkOutput("wait_res_valid", 32'(res_valid), 32'd0);
         if (i == reset_at) begin
            #2;
            reset     = 1'b1;
            ex_valid  = 1'b0;
            mult_done = 1'b0;
            #1;
            model_result = '0;
            model_err    = 1'b0;
            checkOutput("rst_stall", 32'(stall), 32'd0);
            checkOutput("rst_doMult", 32'(doMult), 32'd0);
            checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
            checkOutput("rst_result", result, 32'h0);
            checkOutput("rst_mult_a", mult_a, 32'h0);
            checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
            tick();
            reset = 1'b0;
            return;
         end
         tick();
         if (i == done_delay) break;
      end

      // DONE cycle: a mult opcode is still on EX but must not relaunch
      model_result = exp_res;
      model_err    = model_err | timed_out;
      ex_valid     = 1'b1;
      ALU_ctr      = C_MULT;
      mult_done    = 1'b0;
      mult_res     = $urandom;
      multu_res    = $urandom;
      #1;
      checkOutput("done_res_valid", 32'(res_valid), 32'd1);
      checkOutput("done_stall", 32'(stall), 32'd0);
      checkOutput("done_result", result, model_result);
      checkOutput("done_timeout_err", 32'(timeout_err), 32'(model_err));
      tick();

      if (idle_after) begin
         ex_valid  = 1'b0;
         mult_done = stale;
         #1;
         checkOutput("post_doMult", 32'(doMult), 32'd0);
         checkOutput("post_stall", 32'(stall), 32'd0);
         checkOutput("post_res_valid", 32'(res_valid), 32'd0);
         checkOutput("post_result", result, model_result);
         tick();
         checkOutput("post2_doMult", 32'(doMult), 32'd0);
         checkOutput("post2_timeout_err", 32'(timeout_err), 32'(model_err));
      end
   endtask

   initial begin
      logic [5:0] code;
      reset     = 1'b1;
      ex_valid  = 1'b0;
      ALU_ctr   = '0;
      busA      = '0;
      busB      = '0;
      mult_done = 1'b0;
      mult_res  = '0;
      multu_res = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_doMult", 32'(doMult), 32'd0);
      checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
      checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
      checkOutput("reset_result", result, 32'h0);
      checkOutput("reset_mult_b", mult_b, 32'h0);
      reset = 1'b0;
      tick();

      applyStimulus(1'b1, 32'hFFFF_FFFD, 32'd7, 4, 1'b0, 1'b1, -1);
      checkOutput("signed_value", model_result, 32'hFFFF_FFEB);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd2, 3, 1'b0, 1'b1, -1);
      checkOutput("unsigned_value", model_result, 32'hFFFF_FFFE);

      // non-mult opcodes with a stale mult_done must leave the FSM idle
      for (int i = 0; i < 6; i++) begin
         code = (i == 0) ? 6'h20 : 6'($urandom);
         if (code == C_MULT || code == C_MULTU) code = 6'h20;
         ex_valid  = (i != 5);
         ALU_ctr   = (i == 5) ? C_MULT : code;
         mult_done = 1'b1;
         #1;
         checkOutput("nonmult_stall", 32'(stall), 32'd0);
         checkOutput("nonmult_doMult", 32'(doMult), 32'd0);
         tick();
         checkOutput("nonmult_next_doMult", 32'(doMult), 32'd0);
         checkOutput("nonmult_res_valid", 32'(res_valid), 32'd0);
      end
      mult_done = 1'b0;

      // back-to-back with stale done during IDLE/LAUNCH
      applyStimulus(1'b1, 32'd12345, 32'hFFFF_FF00, 2, 1'b1, 1'b0, -1);
      applyStimulus(1'b0, 32'h8000_0001, 32'd3, 0, 1'b1, 1'b0, -1);
      applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6, 1'b1, 1'b1, -1);

      // timeout, then a good op keeps the sticky flag; then done on the last cycle
      applyStimulus(1'b1, 32'd5, 32'd6, TIMEOUT + 5, 1'b0, 1'b1, -1);
      applyStimulus(1'b0, 32'd9, 32'd11, 1, 1'b0, 1'b1, -1);
      applyStimulus(1'b1, 32'hFFFF_FFF0, 32'd4, TIMEOUT - 1, 1'b0, 1'b1, -1);

      for (int n = 0; n < 15; n++) begin
         applyStimulus(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 12)),
                       1'($urandom), 1'($urandom), -1);
      end

      // reset on the third WAIT cycle, then a normal op
      applyStimulus(1'b0, 32'd100, 32'd200, 10, 1'b0, 1'b1, 2);
      applyStimulus(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5, 1'b0, 1'b1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
